// File: rtl/svc_rv_ras.sv
// -----------------------------------------------------------------------------
// svc_rv_ras -- return address stack for the RISC-V fetch front end.
//
// Calls push their link address and returns pop it. The current top of stack
// is offered to the PC-select arbiter as a return-target prediction. A
// pointer/count checkpoint travels down the pipeline so that a MEM-stage
// misprediction can roll the stack back to its state at that instruction.
//
// Configuration macro:
//   SVC_RV_RAS_BYPASS_EN  when defined, a same-cycle push is forwarded
//                         combinationally onto ras_valid/ras_target.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   push_en        call detected; push push_addr
//   push_addr      link address (call PC + 4)
//   pop_en         return predicted; pop top entry
//   restore_en     misprediction recovery; load checkpoint
//   restore_tos    checkpointed top-of-stack pointer
//   restore_count  checkpointed occupancy (values above DEPTH are clamped)
//   ras_valid      stack non-empty
//   ras_target     entry at top of stack
//   ckpt_tos       current top-of-stack pointer (registered)
//   ckpt_count     current occupancy (registered)
// -----------------------------------------------------------------------------
module svc_rv_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_en,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop_en,
    input  logic             restore_en,
    input  logic [PTR_W-1:0] restore_tos,
    input  logic [CNT_W-1:0] restore_count,
    output logic             ras_valid,
    output logic [XLEN-1:0]  ras_target,
    output logic [PTR_W-1:0] ckpt_tos,
    output logic [CNT_W-1:0] ckpt_count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    // Reset pointer sits one below entry 0 so the first push lands in entry 0.
    localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH - 1);

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] tos_inc;
    logic             not_empty;

    // DEPTH is a power of two, so the pointer wraps naturally.
    assign tos_inc   = tos + PTR_W'(1);
    assign not_empty = (count != '0);

    // NOTE: the stack array is reset explicitly because the reset target must
    // read back as zero; this forces flops rather than a RAM macro, which is
    // acceptable at these depths. All state here uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos   <= TOS_RST;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (restore_en) begin
            // Pipeline is flushing: push/pop this cycle belong to squashed
            // instructions. Entries are left alone; a stale target is caught
            // downstream by JALR verification.
            tos   <= restore_tos;
            count <= (restore_count > CNT_FULL) ? CNT_FULL : restore_count;
        end else if (push_en && pop_en && not_empty) begin
            // Return-then-call: replace the top in place.
            stack[tos] <= push_addr;
        end else if (push_en) begin
            // At full the oldest entry is overwritten circularly.
            tos             <= tos_inc;
            stack[tos_inc]  <= push_addr;
            if (count != CNT_FULL) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop_en && not_empty) begin
            // Popping an empty stack is ignored.
            tos   <= tos - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        ras_valid  = not_empty;
        ras_target = stack[tos];
`ifdef SVC_RV_RAS_BYPASS_EN
        // Forward a same-cycle call so an immediately following return
        // predicts correctly.
        if (push_en && !restore_en) begin
            ras_valid  = 1'b1;
            ras_target = push_addr;
        end
`endif
    end

    assign ckpt_tos   = tos;
    assign ckpt_count = count;

endmodule

// File: tb/tb_svc_rv_ras.sv
// -----------------------------------------------------------------------------
// tb_svc_rv_ras -- directed self-checking bench for svc_rv_ras.
// u_dut uses the default DEPTH=8; u_dut4 (DEPTH=4) shares the stimulus and is
// used for the circular-overflow case.
// -----------------------------------------------------------------------------
module tb_svc_rv_ras;

    logic        clk;
    logic        rst;
    logic        push_en;
    logic [31:0] push_addr;
    logic        pop_en;
    logic        restore_en;
    logic [2:0]  restore_tos;
    logic [3:0]  restore_count;

    logic        ras_valid;
    logic [31:0] ras_target;
    logic [2:0]  ckpt_tos;
    logic [3:0]  ckpt_count;

    logic        ras_valid4;
    logic [31:0] ras_target4;
    logic [1:0]  ckpt_tos4;
    logic [2:0]  ckpt_count4;

    int errors = 0;
    int checks = 0;

    logic [2:0] saved_tos;
    logic [3:0] saved_count;

    svc_rv_ras u_dut (
        .clk           (clk),
        .rst           (rst),
        .push_en       (push_en),
        .push_addr     (push_addr),
        .pop_en        (pop_en),
        .restore_en    (restore_en),
        .restore_tos   (restore_tos),
        .restore_count (restore_count),
        .ras_valid     (ras_valid),
        .ras_target    (ras_target),
        .ckpt_tos      (ckpt_tos),
        .ckpt_count    (ckpt_count)
    );

    svc_rv_ras #(.XLEN(32), .DEPTH(4)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .push_en       (push_en),
        .push_addr     (push_addr),
        .pop_en        (pop_en),
        .restore_en    (restore_en),
        .restore_tos   (restore_tos[1:0]),
        .restore_count (restore_count[2:0]),
        .ras_valid     (ras_valid4),
        .ras_target    (ras_target4),
        .ckpt_tos      (ckpt_tos4),
        .ckpt_count    (ckpt_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic push, input logic pop, input logic [31:0] addr);
        push_en   = push;
        pop_en    = pop;
        push_addr = addr;
        tick();
        push_en   = 1'b0;
        pop_en    = 1'b0;
        push_addr = '0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        push_en       = 1'b0;
        push_addr     = '0;
        pop_en        = 1'b0;
        restore_en    = 1'b0;
        restore_tos   = '0;
        restore_count = '0;
        do_reset();

        // Reset state.
        check("rst_valid", 32'(ras_valid), 32'd0);
        check("rst_target", ras_target, 32'h0);
        check("rst_tos", 32'(ckpt_tos), 32'd7);
        check("rst_count", 32'(ckpt_count), 32'd0);

        // Push three, pop three.
        op(1, 0, 32'h100);
        check("push1_target", ras_target, 32'h100);
        check("push1_valid", 32'(ras_valid), 32'd1);
        op(1, 0, 32'h200);
        check("push2_target", ras_target, 32'h200);
        op(1, 0, 32'h300);
        check("push3_target", ras_target, 32'h300);
        check("push3_tos", 32'(ckpt_tos), 32'd2);
        check("push3_count", 32'(ckpt_count), 32'd3);
        op(0, 1, 32'h0);
        check("pop1_target", ras_target, 32'h200);
        op(0, 1, 32'h0);
        check("pop2_target", ras_target, 32'h100);
        op(0, 1, 32'h0);
        check("pop3_valid", 32'(ras_valid), 32'd0);
        check("pop3_tos", 32'(ckpt_tos), 32'd7);

        // Underflow is ignored.
        op(0, 1, 32'h0);
        check("uflow_tos", 32'(ckpt_tos), 32'd7);
        check("uflow_count", 32'(ckpt_count), 32'd0);
        check("uflow_valid", 32'(ras_valid), 32'd0);

        // Circular overflow on the 4-deep instance.
        do_reset();
        op(1, 0, 32'h10);
        op(1, 0, 32'h20);
        op(1, 0, 32'h30);
        op(1, 0, 32'h40);
        op(1, 0, 32'h50);
        check("ovf_count", 32'(ckpt_count4), 32'd4);
        check("ovf_target", ras_target4, 32'h50);
        check("ovf_tos", 32'(ckpt_tos4), 32'd0);
        op(0, 1, 32'h0);
        check("ovf_pop1", ras_target4, 32'h40);
        op(0, 1, 32'h0);
        check("ovf_pop2", ras_target4, 32'h30);
        op(0, 1, 32'h0);
        check("ovf_pop3", ras_target4, 32'h20);
        check("ovf_pop3_valid", 32'(ras_valid4), 32'd1);
        op(0, 1, 32'h0);
        check("ovf_pop4_valid", 32'(ras_valid4), 32'd0);

        // Simultaneous push+pop replaces the top.
        do_reset();
        op(1, 0, 32'hA0);
        op(1, 1, 32'hB0);
        check("pp_count", 32'(ckpt_count), 32'd1);
        check("pp_target", ras_target, 32'hB0);
        check("pp_tos", 32'(ckpt_tos), 32'd0);
        // Same from empty behaves as a plain push.
        do_reset();
        op(1, 1, 32'hB0);
        check("pp_empty_count", 32'(ckpt_count), 32'd1);
        check("pp_empty_target", ras_target, 32'hB0);
        check("pp_empty_tos", 32'(ckpt_tos), 32'd0);

        // Checkpoint and restore; push during restore is dropped.
        do_reset();
        op(1, 0, 32'h1);
        op(1, 0, 32'h2);
        check("ckpt_tos", 32'(ckpt_tos), 32'd1);
        check("ckpt_count", 32'(ckpt_count), 32'd2);
        saved_tos   = 3'd1;
        saved_count = 4'd2;
        op(1, 0, 32'h3);
        op(0, 1, 32'h0);
        op(0, 1, 32'h0);
        check("pre_restore_target", ras_target, 32'h1);
        restore_en    = 1'b1;
        restore_tos   = saved_tos;
        restore_count = saved_count;
        push_en       = 1'b1;
        push_addr     = 32'hEE;
        tick();
        restore_en = 1'b0;
        push_en    = 1'b0;
        push_addr  = '0;
        #1;
        check("restore_target", ras_target, 32'h2);
        check("restore_count", 32'(ckpt_count), 32'd2);
        check("restore_tos", 32'(ckpt_tos), 32'd1);

        // Illegal restore count clamps to DEPTH.
        restore_en    = 1'b1;
        restore_tos   = 3'd2;
        restore_count = 4'd15;
        tick();
        restore_en = 1'b0;
        #1;
        check("clamp_count", 32'(ckpt_count), 32'd8);
        check("clamp_target", ras_target, 32'h3);

        // Reset overrides push and restore mid-sequence.
        op(1, 0, 32'h55);
        rst           = 1'b1;
        restore_en    = 1'b1;
        restore_tos   = 3'd2;
        restore_count = 4'd3;
        push_en       = 1'b1;
        push_addr     = 32'h77;
        tick();
        rst        = 1'b0;
        restore_en = 1'b0;
        push_en    = 1'b0;
        push_addr  = '0;
        #1;
        check("midrst_tos", 32'(ckpt_tos), 32'd7);
        check("midrst_count", 32'(ckpt_count), 32'd0);
        check("midrst_target", ras_target, 32'h0);

        // Same-cycle visibility of a push depends on the bypass option.
        push_en   = 1'b1;
        push_addr = 32'hC0;
        #1;
`ifdef SVC_RV_RAS_BYPASS_EN
        check("byp_same_valid", 32'(ras_valid), 32'd1);
        check("byp_same_target", ras_target, 32'hC0);
`else
        check("byp_same_valid", 32'(ras_valid), 32'd0);
        check("byp_same_target", ras_target, 32'h0);
`endif
        tick();
        push_en   = 1'b0;
        push_addr = '0;
        #1;
        check("byp_next_valid", 32'(ras_valid), 32'd1);
        check("byp_next_target", ras_target, 32'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
